// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle control unit.
// Optional link ops (jrsal/baln) are enabled by MC_LINK_OPS_EN.
package mc_pkg;

  localparam int OP_W_DEF = 6;
  localparam int WAIT_W   = 4;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_JRSAL = 6'h11;
  localparam logic [5:0] OP_BALN  = 6'h19;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ORIEX  = 4'd9,
    S_ORIWB  = 4'd10,
    S_JRSAL  = 4'd11,
    S_BALN   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2,
    ALU_OR    = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG   = 2'd0,
    SRCB_FOUR  = 2'd1,
    SRCB_IMM   = 2'd2,
    SRCB_SHIMM = 2'd3
  } srcb_t;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'd0,
    PCS_ALUOUT = 2'd1,
    PCS_JUMP   = 2'd2,
    PCS_REG    = 2'd3
  } pc_src_t;

  typedef struct packed {
    logic r;
    logic lw;
    logic sw;
    logic beq;
    logic ori;
    logic jrsal;
    logic baln;
    logic bad;
  } op_class_t;

  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    logic    branch_on_neg;
    logic    iord;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    mem_to_reg;
    logic    reg_dst;
    logic    reg_write;
    logic    link_write;
    logic    alu_src_a;
    srcb_t   alu_src_b;
    alu_op_t alu_op;
    pc_src_t pc_src;
    logic    instr_done;
    logic    illegal;
    logic    timeout;
  } ctl_t;

endpackage

// File: rtl/multicycle_control_opdecode.sv
// Opcode classifier: maps the IR opcode to one-hot instruction classes.
// jrsal/baln are recognised only when MC_LINK_OPS_EN is defined.
module mc_opdecode
  import mc_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0] opcode,
  output op_class_t       cls
);

  logic       hi_zero;
  logic [5:0] op6;

  assign op6 = opcode[5:0];

  // Wider opcode buses must carry zeros above bit 5 to match.
  generate
    if (OP_W > 6) begin : g_hi
      assign hi_zero = ~|opcode[OP_W-1:6];
    end else begin : g_nohi
      assign hi_zero = 1'b1;
    end
  endgenerate

  always_comb begin
    cls = '0;
    if (hi_zero) begin
      cls.r   = (op6 == OP_R);
      cls.lw  = (op6 == OP_LW);
      cls.sw  = (op6 == OP_SW);
      cls.beq = (op6 == OP_BEQ);
      cls.ori = (op6 == OP_ORI);
`ifdef MC_LINK_OPS_EN
      cls.jrsal = (op6 == OP_JRSAL);
      cls.baln  = (op6 == OP_BALN);
`endif
    end
    cls.bad = ~|{cls.r, cls.lw, cls.sw, cls.beq,
                 cls.ori, cls.jrsal, cls.baln};
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with memory wait counter and abort.
// Define MC_LINK_OPS_EN to enable the jrsal/baln link instructions.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OP_W        = OP_W_DEF,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            branch_on_neg,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            link_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic            instr_done,
  output logic            illegal,
  output logic            timeout,
  output logic [3:0]      state
);

  state_t            cur, nxt;
  logic [WAIT_W-1:0] wcnt, wcnt_n;
  op_class_t         cls;
  ctl_t              ctl;
  logic              waiting;
  logic              abort;

  mc_opdecode #(.OP_W(OP_W)) u_dec (
    .opcode (opcode),
    .cls    (cls)
  );

  assign waiting = (cur == S_FETCH) || (cur == S_MEMRD) ||
                   (cur == S_MEMWR);
  assign abort   = (MEM_TIMEOUT != 0) && waiting &&
                   (int'(wcnt) == MEM_TIMEOUT);

  always_comb begin
    ctl = '0;
    nxt = cur;
    unique case (cur)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        if (abort) begin
          ctl.mem_read = 1'b0;
          ctl.timeout  = 1'b1;
          nxt          = S_FETCH;
        end else if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          nxt          = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_SHIMM;
        unique case (1'b1)
          cls.lw, cls.sw: nxt = S_MEMADR;
          cls.r:          nxt = S_EXEC;
          cls.beq:        nxt = S_BRANCH;
          cls.ori:        nxt = S_ORIEX;
          cls.jrsal:      nxt = S_JRSAL;
          cls.baln:       nxt = S_BALN;
          default: begin
            ctl.illegal = 1'b1;
            nxt         = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        if (cls.lw)      nxt = S_MEMRD;
        else if (cls.sw) nxt = S_MEMWR;
        else             nxt = S_FETCH;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (abort) begin
          ctl.mem_read = 1'b0;
          ctl.timeout  = 1'b1;
          nxt          = S_FETCH;
        end else if (mem_ready) begin
          nxt = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
        nxt            = S_FETCH;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        if (abort) begin
          ctl.mem_write = 1'b0;
          ctl.timeout   = 1'b1;
          nxt           = S_FETCH;
        end else if (mem_ready) begin
          ctl.instr_done = 1'b1;
          nxt            = S_FETCH;
        end
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALU_FUNCT;
        nxt           = S_RWB;
      end
      S_RWB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
        nxt            = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_src        = PCS_ALUOUT;
        ctl.instr_done    = 1'b1;
        nxt               = S_FETCH;
      end
      S_ORIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_OR;
        nxt           = S_ORIWB;
      end
      S_ORIWB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        nxt            = S_FETCH;
      end
      S_JRSAL: begin
        ctl.alu_src_a  = 1'b1;
        ctl.pc_write   = 1'b1;
        ctl.pc_src     = PCS_REG;
`ifdef MC_LINK_OPS_EN
        ctl.link_write = 1'b1;
`endif
        ctl.instr_done = 1'b1;
        nxt            = S_FETCH;
      end
      S_BALN: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
`ifdef MC_LINK_OPS_EN
        ctl.branch_on_neg = 1'b1;
        ctl.link_write    = 1'b1;
`endif
        ctl.pc_src        = PCS_ALUOUT;
        ctl.instr_done    = 1'b1;
        nxt               = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Counter restarts whenever a wait state is (re)entered.
  always_comb begin
    wcnt_n = wcnt;
    if (abort || (nxt != cur))
      wcnt_n = '0;
    else if (waiting && !mem_ready && (wcnt != '1))
      wcnt_n = wcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= S_FETCH;
      wcnt <= '0;
    end else begin
      cur  <= nxt;
      wcnt <= wcnt_n;
    end
  end

  // Reset masks every output combinationally, FETCH included.
  assign pc_write      = reset ? 1'b0 : ctl.pc_write;
  assign pc_write_cond = reset ? 1'b0 : ctl.pc_write_cond;
  assign branch_on_neg = reset ? 1'b0 : ctl.branch_on_neg;
  assign iord          = reset ? 1'b0 : ctl.iord;
  assign mem_read      = reset ? 1'b0 : ctl.mem_read;
  assign mem_write     = reset ? 1'b0 : ctl.mem_write;
  assign ir_write      = reset ? 1'b0 : ctl.ir_write;
  assign mem_to_reg    = reset ? 1'b0 : ctl.mem_to_reg;
  assign reg_dst       = reset ? 1'b0 : ctl.reg_dst;
  assign reg_write     = reset ? 1'b0 : ctl.reg_write;
  assign link_write    = reset ? 1'b0 : ctl.link_write;
  assign alu_src_a     = reset ? 1'b0 : ctl.alu_src_a;
  assign alu_src_b     = reset ? 2'd0 : ctl.alu_src_b;
  assign alu_op        = reset ? 2'd0 : ctl.alu_op;
  assign pc_src        = reset ? 2'd0 : ctl.pc_src;
  assign instr_done    = reset ? 1'b0 : ctl.instr_done;
  assign illegal       = reset ? 1'b0 : ctl.illegal;
  assign timeout       = reset ? 1'b0 : ctl.timeout;
  assign state         = reset ? 4'd0 : cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT = 4).
// Link-op expectations follow MC_LINK_OPS_EN.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_on_neg, iord;
  logic       mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, link_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       instr_done, illegal, timeout;
  logic [3:0] state;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  multicycle_control #(.OP_W(6), .MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_on_neg (branch_on_neg),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .link_write    (link_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .instr_done    (instr_done),
    .illegal       (illegal),
    .timeout       (timeout),
    .state         (state)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    tick();
    tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_irw", 32'(ir_write), 0);
    chk("rst_pcw", 32'(pc_write), 0);
    chk("rst_rd", 32'(mem_read), 0);
    chk("rst_srcb", 32'(alu_src_b), 0);

    reset = 1'b0;
    #1;
    chk("fetch_irw", 32'(ir_write), 1);
    chk("fetch_pcw", 32'(pc_write), 1);
    chk("fetch_rd", 32'(mem_read), 1);
    chk("fetch_srcb", 32'(alu_src_b), 1);
    tick();
    chk("dec_state", 32'(state), 1);
    chk("dec_srcb", 32'(alu_src_b), 3);
    chk("dec_ill", 32'(illegal), 0);
    tick();
    chk("exec_state", 32'(state), 6);
    chk("exec_aluop", 32'(alu_op), 2);
    chk("exec_srca", 32'(alu_src_a), 1);
    tick();
    chk("rwb_state", 32'(state), 7);
    chk("rwb_ctl", {reg_write, reg_dst, instr_done}, 3'b111);
    tick();
    chk("rwb_ret", 32'(state), 0);

    opcode = 6'h23;
    tick();
    tick();
    chk("lw_adr", 32'(state), 2);
    chk("lw_adr_srcb", 32'(alu_src_b), 2);
    mem_ready = 1'b0;
    tick();
    chk("lw_rd1", 32'(state), 3);
    chk("lw_rd_ctl", {mem_read, iord, mem_write}, 3'b110);
    tick();
    tick();
    tick();
    mem_ready = 1'b1;
    #1;
    chk("lw_rd4", 32'(state), 3);
    chk("lw_rd4_to", 32'(timeout), 0);
    tick();
    chk("lw_wb", 32'(state), 4);
    chk("lw_wb_ctl", {reg_write, mem_to_reg, instr_done}, 3'b111);
    tick();
    chk("lw_ret", 32'(state), 0);

    opcode = 6'h3F;
    tick();
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_nowr", {reg_write, pc_write}, 2'b00);
    tick();
    chk("ill_ret", 32'(state), 0);
    chk("ill_clr", 32'(illegal), 0);

    opcode = 6'h04;
    tick();
    tick();
    chk("beq_state", 32'(state), 8);
    chk("beq_ctl", {pc_write_cond, pc_src, alu_op, instr_done},
        6'b1_01_01_1);
    tick();

    opcode = 6'h0D;
    tick();
    tick();
    chk("oriex", {state, alu_op, alu_src_b}, {4'd9, 2'd3, 2'd2});
    tick();
    chk("oriwb", {state, reg_write, reg_dst, instr_done},
        {4'd10, 3'b101});
    tick();

    opcode = 6'h2B;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    chk("sw_wr1", {state, mem_write, mem_read}, {4'd5, 2'b10});
    tick();
    tick();
    tick();
    chk("sw_wr4_to", 32'(timeout), 0);
    tick();
    chk("sw_to", 32'(timeout), 1);
    chk("sw_to_wr", 32'(mem_write), 0);
    chk("sw_to_done", 32'(instr_done), 0);
    tick();
    chk("sw_to_ret", 32'(state), 0);
    chk("sw_to_irw", {ir_write, timeout}, 2'b00);
    mem_ready = 1'b1;
    #1;
    chk("fetch_again", 32'(ir_write), 1);

    opcode = 6'h19;
    tick();
`ifdef MC_LINK_OPS_EN
    chk("baln_dec_ill", 32'(illegal), 0);
    tick();
    chk("baln_state", 32'(state), 12);
    chk("baln_ctl", {branch_on_neg, link_write, pc_src},
        4'b11_01);
    tick();
`else
    chk("baln_ill", 32'(illegal), 1);
    tick();
    chk("baln_ret", 32'(state), 0);
    chk("baln_link", 32'(link_write), 0);
`endif

    opcode = 6'h2B;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    chk("rst_wr1", 32'(mem_write), 1);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_wr_now", 32'(mem_write), 0);
    tick();
    chk("rst_wr_st", 32'(state), 0);
    reset = 1'b0;
    #1;
    chk("post_rst", {state, mem_read, ir_write}, {4'd0, 2'b10});

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OP_W, default 6: opcode field width; decode compares only opcode[5:0], and any upper bits SHALL be zero for a legal match.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum wait cycles on mem_ready before an abort; a value of 0 SHALL disable the timeout.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- opcode  in  OP_W  instruction opcode held in the IR.
- mem_ready  in  1  memory handshake complete.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load gated by branch condition.
- branch_on_neg  out  1  select the N flag instead of Z for pc_write_cond.
- iord  out  1  memory address from ALUOut instead of PC.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-back data from MDR.
- reg_dst  out  1  destination is rd.
- reg_write  out  1  register file write.
- link_write  out  1  write PC to $ra.
- alu_src_a  out  1  ALU A input is a register (0 = PC).
- alu_src_b  out  2  0 = reg, 1 = const 4, 2 = sign-extended immediate, 3 = shifted immediate.
- alu_op  out  2  0 = add, 1 = sub, 2 = funct, 3 = or.
- pc_src  out  2  0 = ALU, 1 = ALUOut, 2 = jump, 3 = register.
- instr_done  out  1  one-cycle pulse on instruction retire.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- timeout  out  1  one-cycle pulse on a memory abort.
- state  out  4  current state, for debug.

Function
REQ-004 Opcodes: R = 0x00, lw = 0x23, sw = 0x2B, beq = 0x04, ori = 0x0D, jrsal = 0x11, baln = 0x19.
REQ-005 States: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, RWB = 7, BRANCH = 8, ORIEX = 9, ORIWB = 10, JRSAL = 11, BALN = 12; codes 13-15 are unused.
REQ-006 All outputs SHALL be Moore outputs of the state register; any signal not listed for a state SHALL be 0.
REQ-007 FETCH: mem_read = 1, alu_src_b = 1.
- While mem_ready = 0, remain in FETCH with ir_write = 0 and pc_write = 0.
- In the cycle mem_ready = 1 (Mealy exception), assert ir_write = 1 and pc_write = 1, then go to DECODE.
REQ-008 DECODE: alu_src_b = 3; next state by opcode:
- lw or sw -> MEMADR; R -> EXEC; beq -> BRANCH; ori -> ORIEX; jrsal -> JRSAL; baln -> BALN.
- Any other opcode -> FETCH, with illegal pulsed in that cycle.
REQ-009 MEMADR: alu_src_a = 1, alu_src_b = 2; lw -> MEMRD, sw -> MEMWR.
REQ-010 MEMRD: mem_read = 1, iord = 1; remain until mem_ready = 1, then -> MEMWB.
REQ-011 MEMWB: reg_write = 1, mem_to_reg = 1, instr_done = 1; -> FETCH.
REQ-012 MEMWR: mem_write = 1, iord = 1; remain until mem_ready = 1, then assert instr_done in that cycle and -> FETCH.
REQ-013 EXEC: alu_src_a = 1, alu_op = 2; -> RWB.
REQ-014 RWB: reg_write = 1, reg_dst = 1, instr_done = 1; -> FETCH.
REQ-015 BRANCH: alu_src_a = 1, alu_op = 1, pc_write_cond = 1, pc_src = 1, instr_done = 1; -> FETCH.
REQ-016 ORIEX: alu_src_a = 1, alu_src_b = 2, alu_op = 3; -> ORIWB.
REQ-017 ORIWB: reg_write = 1, instr_done = 1; -> FETCH.
REQ-018 JRSAL: alu_src_a = 1, pc_write = 1, pc_src = 3, link_write = 1, instr_done = 1; -> FETCH.
REQ-019 BALN: alu_src_a = 1, alu_op = 1, pc_write_cond = 1, branch_on_neg = 1, pc_src = 1, link_write = 1, instr_done = 1; -> FETCH.
REQ-020 Wait counter: 4 bits, saturating; cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle mem_ready = 0 in those states.
REQ-021 With MEM_TIMEOUT ≠ 0, when the wait counter reaches MEM_TIMEOUT: pulse timeout, drop the request, -> FETCH; the PC is not written and instr_done is not pulsed.
REQ-022 An unused state code SHALL transition to FETCH on the next cycle with all outputs 0.
REQ-023 mem_read and mem_write SHALL never be asserted in the same cycle.

Reset
REQ-024 With reset = 1 at a clock edge: state = FETCH and wait counter = 0.
REQ-025 While reset is high, all outputs SHALL be 0, including the FETCH outputs.
REQ-026 Reset SHALL override any state, including a pending mem_ready wait.

Configuration
REQ-027 Macro MC_LINK_OPS_EN, when defined: JRSAL and BALN are present and link_write / branch_on_neg are functional.
REQ-028 Without MC_LINK_OPS_EN: opcodes 0x11 and 0x19 decode as illegal; link_write and branch_on_neg are tied to 0.

Structure
REQ-029 Package mc_pkg SHALL hold the opcode constants, the state enum (4-bit), the alu_op, alu_src_b and pc_src encodings, and the OP_W default.
REQ-030 The opcode decoder SHALL be the combinational sub-module mc_opdecode (opcode -> one-hot class flags); the FSM, wait counter and output decode live in multicycle_control.

Verification
REQ-031 reset high for 2 cycles then low, mem_ready = 1 -> state 0 during reset; then FETCH (ir_write = 1, pc_write = 1) -> DECODE in 1 cycle each.
REQ-032 lw (0x23), mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with reg_write = 1, mem_to_reg = 1, instr_done = 1; 5 states total plus wait.
REQ-033 Opcode 0x3F -> illegal pulse in DECODE, back to FETCH; no reg_write or pc_write.
REQ-034 MEM_TIMEOUT = 4, sw with mem_ready held low -> timeout pulse after 4 wait cycles; mem_write drops; FETCH; no instr_done.
REQ-035 baln (0x19) with MC_LINK_OPS_EN -> BALN asserts branch_on_neg = 1, link_write = 1, pc_src = 1; without the macro -> illegal pulse.
REQ-036 reset asserted mid-MEMWR -> state = FETCH next cycle; mem_write = 0 immediately.
